// File: rtl/bus_arb_mux.sv
// bus_arb_mux: registered datapath bus. Each cycle one word source or the
// sign-extended immediate is chosen and loaded onto bus_out. In direct mode
// the one-hot select comes from the control unit: if more than one select
// is set, the lowest index wins and a conflict is flagged. In arbitrated
// mode requests are served round-robin starting at rr_ptr.
// Every output comes from a flop.
module bus_arb_mux #(
    parameter int WORD_W  = 32,
    parameter int NUM_SRC = 23,
    parameter int IMM_W   = 19,
    parameter int IDX_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      mode,
    input  logic [NUM_SRC-1:0]        src_out,
    input  logic [NUM_SRC*WORD_W-1:0] src_data,
    input  logic                      imm_out,
    input  logic [IMM_W-1:0]          imm_val,
    input  logic                      conflict_clr,
    output logic [WORD_W-1:0]         bus_out,
    output logic                      bus_valid,
    output logic [NUM_SRC:0]          grant,
    output logic [IDX_W-1:0]          sel_idx,
    output logic                      conflict,
    output logic                      conflict_sticky
);

    localparam int NREQ = NUM_SRC + 1;

    logic [NREQ-1:0]   req;
    logic [WORD_W-1:0] imm_word;
    logic [WORD_W-1:0] sel_word;
    logic              found;
    logic              multi;
    logic [IDX_W-1:0]  win;
    int                idx;

    logic [WORD_W-1:0] bus_q, bus_d;
    logic              valid_q, valid_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic              conflict_q, conflict_d;
    logic              sticky_q, sticky_d;
    logic [IDX_W-1:0]  rr_q, rr_d;

    // Pick the winner: fixed lowest-index priority in direct mode,
    // rotating search from rr_ptr in arbitrated mode.
    always_comb begin
        req      = {imm_out, src_out};
        imm_word = {{(WORD_W - IMM_W){imm_val[IMM_W-1]}}, imm_val};
        found    = 1'b0;
        win      = '0;
        idx      = 0;
        if (!mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i]) begin
                    found = 1'b1;
                    win   = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    win   = IDX_W'(idx);
                end
            end
        end
        // More than one bit set: clearing the lowest set bit leaves something.
        multi = (req & (req - NREQ'(1))) != '0;
    end

    // Word mux for the winner; the immediate occupies the last index.
    always_comb begin
        sel_word = imm_word;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win == IDX_W'(i)) sel_word = src_data[i*WORD_W +: WORD_W];
        end
    end

    // Next-state for the output registers and the round-robin pointer.
    always_comb begin
        bus_d      = bus_q;
        valid_d    = 1'b0;
        grant_d    = '0;
        sel_d      = sel_q;
        rr_d       = rr_q;
        conflict_d = 1'b0;
        if (found) begin
            bus_d   = sel_word;
            valid_d = 1'b1;
            grant_d = NREQ'(1) << win;
            sel_d   = win;
            if (mode) begin
                rr_d = (win == IDX_W'(NUM_SRC)) ? '0 : win + IDX_W'(1);
            end else begin
                conflict_d = multi;
            end
        end
        // A new conflict takes priority over a clear arriving in the same cycle.
        sticky_d = conflict_d | (sticky_q & ~conflict_clr);
    end

    // Single register stage; async active-low clear discards any pending selection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus_q      <= '0;
            valid_q    <= 1'b0;
            grant_q    <= '0;
            sel_q      <= '0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            rr_q       <= '0;
        end else begin
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            conflict_q <= conflict_d;
            sticky_q   <= sticky_d;
            rr_q       <= rr_d;
        end
    end

    assign bus_out         = bus_q;
    assign bus_valid       = valid_q;
    assign grant           = grant_q;
    assign sel_idx         = sel_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Testbench for bus_arb_mux: table of directed vectors plus hand-written
// reset sequences.
module tb_bus_arb_mux;

    localparam int WORD_W  = 32;
    localparam int NUM_SRC = 23;
    localparam int IMM_W   = 19;
    localparam int IDX_W   = 5;

    logic                      clk = 1'b0;
    logic                      clr;
    logic                      mode;
    logic [NUM_SRC-1:0]        src_out;
    logic [NUM_SRC*WORD_W-1:0] src_data;
    logic                      imm_out;
    logic [IMM_W-1:0]          imm_val;
    logic                      conflict_clr;
    logic [WORD_W-1:0]         bus_out;
    logic                      bus_valid;
    logic [NUM_SRC:0]          grant;
    logic [IDX_W-1:0]          sel_idx;
    logic                      conflict;
    logic                      conflict_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic               mode;
        logic [NUM_SRC-1:0] src;
        logic               imm;
        logic [IMM_W-1:0]   imm_val;
        logic               cclr;
        logic [WORD_W-1:0]  e_bus;
        logic               e_valid;
        logic [NUM_SRC:0]   e_grant;
        logic [IDX_W-1:0]   e_sel;
        logic               e_conf;
        logic               e_sticky;
    } vec_t;

    vec_t vecs[$];

    bus_arb_mux #(.WORD_W(WORD_W), .NUM_SRC(NUM_SRC), .IMM_W(IMM_W)) dut (
        .clk(clk), .clr(clr), .mode(mode), .src_out(src_out), .src_data(src_data),
        .imm_out(imm_out), .imm_val(imm_val), .conflict_clr(conflict_clr),
        .bus_out(bus_out), .bus_valid(bus_valid), .grant(grant), .sel_idx(sel_idx),
        .conflict(conflict), .conflict_sticky(conflict_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_bus, input logic e_valid,
                           input logic [NUM_SRC:0] e_grant, input logic [IDX_W-1:0] e_sel,
                           input logic e_conf, input logic e_sticky);
        chk({tag, " bus_out"},   bus_out, e_bus);
        chk({tag, " bus_valid"}, 32'(bus_valid), 32'(e_valid));
        chk({tag, " grant"},     32'(grant), 32'(e_grant));
        chk({tag, " sel_idx"},   32'(sel_idx), 32'(e_sel));
        chk({tag, " conflict"},  32'(conflict), 32'(e_conf));
        chk({tag, " sticky"},    32'(conflict_sticky), 32'(e_sticky));
    endtask

    task automatic add(input logic m, input logic [NUM_SRC-1:0] s, input logic im,
                       input logic [IMM_W-1:0] iv, input logic cc, input logic [31:0] eb,
                       input logic ev, input logic [NUM_SRC:0] eg, input logic [IDX_W-1:0] es,
                       input logic ec, input logic est);
        vec_t v;
        v.mode = m; v.src = s; v.imm = im; v.imm_val = iv; v.cclr = cc;
        v.e_bus = eb; v.e_valid = ev; v.e_grant = eg; v.e_sel = es;
        v.e_conf = ec; v.e_sticky = est;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic m, input logic [NUM_SRC-1:0] s, input logic im,
                         input logic [IMM_W-1:0] iv, input logic cc);
        mode = m; src_out = s; imm_out = im; imm_val = iv; conflict_clr = cc;
    endtask

    initial begin
        // Source i carries C0DE00ii, except source 5 which carries DEADBEEF.
        for (int i = 0; i < NUM_SRC; i++)
            src_data[i*WORD_W +: WORD_W] = 32'hC0DE0000 | 32'(i);
        src_data[5*WORD_W +: WORD_W] = 32'hDEADBEEF;

        // Direct mode: single select, hold, immediate sign extension.
        add(0, 23'h000020, 0, 19'h0,     0, 32'hDEADBEEF, 1, 24'h000020, 5,  0, 0);
        add(0, 23'h000000, 0, 19'h0,     0, 32'hDEADBEEF, 0, 24'h000000, 5,  0, 0);
        add(0, 23'h000000, 1, 19'h40000, 0, 32'hFFFC0000, 1, 24'h800000, 23, 0, 0);
        add(0, 23'h000000, 1, 19'h00007, 0, 32'h00000007, 1, 24'h800000, 23, 0, 0);
        // Conflicts and the sticky flag.
        add(0, 23'h000208, 0, 19'h0,     0, 32'hC0DE0003, 1, 24'h000008, 3,  1, 1);
        add(0, 23'h000000, 0, 19'h0,     0, 32'hC0DE0003, 0, 24'h000000, 3,  0, 1);
        add(0, 23'h000000, 0, 19'h0,     1, 32'hC0DE0003, 0, 24'h000000, 3,  0, 0);
        add(0, 23'h000208, 0, 19'h0,     1, 32'hC0DE0003, 1, 24'h000008, 3,  1, 1);
        add(0, 23'h000200, 0, 19'h0,     1, 32'hC0DE0009, 1, 24'h000200, 9,  0, 0);
        add(0, 23'h000004, 1, 19'h00007, 0, 32'hC0DE0002, 1, 24'h000004, 2,  1, 1);
        add(0, 23'h000000, 0, 19'h0,     1, 32'hC0DE0002, 0, 24'h000000, 2,  0, 0);
        // Round-robin over {0,4,22} from rr_ptr=0, then drop all requests.
        add(1, 23'h400011, 0, 19'h0,     0, 32'hC0DE0000, 1, 24'h000001, 0,  0, 0);
        add(1, 23'h400011, 0, 19'h0,     0, 32'hC0DE0004, 1, 24'h000010, 4,  0, 0);
        add(1, 23'h400011, 0, 19'h0,     0, 32'hC0DE0016, 1, 24'h400000, 22, 0, 0);
        add(1, 23'h400011, 0, 19'h0,     0, 32'hC0DE0000, 1, 24'h000001, 0,  0, 0);
        add(1, 23'h400011, 0, 19'h0,     0, 32'hC0DE0004, 1, 24'h000010, 4,  0, 0);
        add(1, 23'h400011, 0, 19'h0,     0, 32'hC0DE0016, 1, 24'h400000, 22, 0, 0);
        add(1, 23'h000000, 0, 19'h0,     0, 32'hC0DE0016, 0, 24'h000000, 22, 0, 0);
        // rr_ptr=23: immediate only wins and the pointer wraps to 0.
        add(1, 23'h000000, 1, 19'h7FFFF, 0, 32'hFFFFFFFF, 1, 24'h800000, 23, 0, 0);
        add(1, 23'h000011, 0, 19'h0,     0, 32'hC0DE0000, 1, 24'h000001, 0,  0, 0);
        add(1, 23'h000011, 0, 19'h0,     0, 32'hC0DE0004, 1, 24'h000010, 4,  0, 0);
        // rr_ptr=5; a direct grant of source 0 must leave it at 5, so the next
        // arbitrated search over {0,4} wraps around and lands on 0.
        add(0, 23'h000001, 0, 19'h0,     0, 32'hC0DE0000, 1, 24'h000001, 0,  0, 0);
        add(1, 23'h000011, 0, 19'h0,     0, 32'hC0DE0000, 1, 24'h000001, 0,  0, 0);
        add(1, 23'h000011, 0, 19'h0,     0, 32'hC0DE0004, 1, 24'h000010, 4,  0, 0);

        // Reset held with a select present: everything stays at zero.
        clr = 1'b0;
        drive(0, 23'h000001, 0, 19'h0, 0);
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 32'h0, 0, 24'h0, 0, 0, 0);
        @(negedge clk);
        clr = 1'b1;
        drive(0, 23'h000000, 0, 19'h0, 0);
        @(posedge clk);
        #1 chk_all("release", 32'h0, 0, 24'h0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].mode, vecs[i].src, vecs[i].imm, vecs[i].imm_val, vecs[i].cclr);
            @(posedge clk);
            #1 chk_all($sformatf("v%0d", i), vecs[i].e_bus, vecs[i].e_valid, vecs[i].e_grant,
                       vecs[i].e_sel, vecs[i].e_conf, vecs[i].e_sticky);
        end

        // Reset in mid-transfer: a conflict is loaded, then clr drops between edges.
        @(negedge clk);
        drive(0, 23'h000208, 0, 19'h0, 0);
        @(posedge clk);
        #1 chk_all("pre_rst", 32'hC0DE0003, 1, 24'h000008, 3, 1, 1);
        #2 clr = 1'b0;
        #1 chk_all("async_rst", 32'h0, 0, 24'h0, 0, 0, 0);
        @(negedge clk);
        drive(0, 23'h000020, 0, 19'h0, 0);
        @(posedge clk);
        #1 chk_all("rst_discard", 32'h0, 0, 24'h0, 0, 0, 0);
        @(negedge clk);
        clr = 1'b1;
        drive(1, 23'h000011, 0, 19'h0, 0);
        @(posedge clk);
        #1 chk_all("post_rst_rr", 32'hC0DE0000, 1, 24'h000001, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
